// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter: frame state encoding,
// default start-of-frame byte and the round-robin pick function.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

  localparam logic [7:0]  SOF_BYTE_DEFAULT = 8'hA5;
  localparam int unsigned MAX_REQ          = 8;

  // Returns {found, index}: first set bit of mask[n-1:0] scanning upward from
  // ptr and wrapping modulo n.
  function automatic logic [3:0] rr_pick(input logic [7:0]  mask,
                                         input logic [2:0]  ptr,
                                         input int unsigned n);
    logic [3:0]  res;
    int unsigned cand;
    res = 4'b0000;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k < n && !res[3] && mask[cand[2:0]]) begin
        res = {1'b1, cand[2:0]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr_i (wrapping) and reports it both one-hot and as an index.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_mask_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IW-1:0]    idx_o,
  output logic             found_o
);

  logic [3:0] pick;

  always_comb begin
    pick    = rr_pick(8'(req_mask_i), 3'(ptr_i), N_REQ);
    found_o = pick[3];
    idx_o   = pick[IW-1:0];
    grant_o = '0;
    if (pick[3]) begin
      grant_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX write port between N_REQ requesters, granting whole
// packets round-robin and framing each as SOF, ID, payload, checksum.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned MAX_PAYLOAD = 32,
  parameter logic [7:0]  SOF_BYTE    = SOF_BYTE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_full,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_overrun
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_PAYLOAD + 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]       csum_q, csum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_found;

  logic             gnt_valid;
  logic             gnt_last;
  logic [7:0]       gnt_data;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr_arbiter (
    .req_mask_i (i_req_valid),
    .ptr_i      (rr_ptr_q),
    .grant_o    (arb_grant),
    .idx_o      (arb_idx),
    .found_o    (arb_found)
  );

  // The owner's lane is selected through the registered one-hot grant.
  always_comb begin
    gnt_valid = |(i_req_valid & grant_q);
    gnt_last  = |(i_req_last & grant_q);
    gnt_data  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q[i]) begin
        gnt_data = gnt_data | i_req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    csum_d      = csum_q;
    cnt_d       = cnt_q;
    overrun_d   = 1'b0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    o_req_ready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d  = arb_grant;
          idx_d    = arb_idx;
          rr_ptr_d = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
          state_d  = ST_SOF;
        end
      end
      ST_SOF: begin
        o_tx_valid = 1'b1;
        o_tx_data  = SOF_BYTE;
        if (!i_tx_full) state_d = ST_ID;
      end
      ST_ID: begin
        o_tx_valid = 1'b1;
        o_tx_data  = 8'(idx_q);
        if (!i_tx_full) begin
          csum_d  = 8'(idx_q);
          cnt_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        o_tx_valid  = gnt_valid;
        o_tx_data   = gnt_data;
        o_req_ready = grant_q & {N_REQ{!i_tx_full}};
        if (gnt_valid && !i_tx_full) begin
          csum_d = csum_q + gnt_data;
          cnt_d  = cnt_q + CW'(1);
          if (gnt_last) begin
            state_d = ST_CSUM;
          end else if (cnt_q == CW'(MAX_PAYLOAD - 1)) begin
            // Cut the packet; the requester's leftover bytes open its next frame.
            state_d   = ST_CSUM;
            overrun_d = 1'b1;
          end
        end
      end
      ST_CSUM: begin
        o_tx_valid = 1'b1;
        o_tx_data  = csum_q;
        if (!i_tx_full) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      csum_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      csum_q    <= csum_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: requester queues feed the DUT, a packet-level model
// predicts every framed byte, grant and strobe cycle by cycle.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXP = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*N-1:0]   req_data;
  logic [7:0]       tx_data;
  logic             tx_valid, tx_full, busy, overrun;

  uart_tx_arbiter #(.N_REQ(N), .MAX_PAYLOAD(MAXP), .SOF_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_tx_data   (tx_data),
    .o_tx_valid  (tx_valid),
    .i_tx_full   (tx_full),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requester sources ({last, data}) and the model's copy of the same packets.
  typedef logic [8:0] ent_t;
  ent_t src_q [N][$];
  ent_t ref_q [N][$];
  bit   pause [N];

  int full_pct = 0, pause_pct = 0, full_hold = 0, init_left = 0;
  int test_mode = 0, cyc = 0, ovr_count = 0, stall_cycles = 0;
  bit rst_arm = 0, full_done = 0, post_rst = 0;

  logic [7:0]   wire_log [$];
  logic [N-1:0] grant_log [$];
  int           start_log [$];

  // Packet-level model state.
  bit         m_busy = 0, m_ovr_frame = 0, ovr_due = 0;
  bit         prev_hold = 0, prev_busy = 0;
  logic [7:0] prev_data = '0;
  int         m_idx = 0, m_ptr = 0, m_pos = 0;
  logic [7:0] m_frame [$];
  logic [N-1:0] hs;

  task automatic push_byte(input int k, input logic [7:0] d, input bit last);
    src_q[k].push_back({last, d});
    ref_q[k].push_back({last, d});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !pause[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = src_q[i][0][7:0];
        req_last[i]         = src_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // Expected frame: SOF, id, up to MAXP bytes of the owner's stream, sum mod 256.
  task automatic build_frame(input int k);
    int   sum, n;
    bit   done;
    ent_t e;
    m_frame.delete();
    m_frame.push_back(8'hA5);
    m_frame.push_back(8'(k));
    sum = k; n = 0; done = 0; m_ovr_frame = 0;
    while (!done && ref_q[k].size() > 0) begin
      e = ref_q[k].pop_front();
      m_frame.push_back(e[7:0]);
      sum += int'(e[7:0]);
      n++;
      if (e[8]) done = 1;
      else if (n == MAXP) begin done = 1; m_ovr_frame = 1; end
    end
    m_frame.push_back(8'(sum));
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_pos = 0; m_frame.delete();
    ovr_due = 0; prev_hold = 0; prev_busy = 0; hs = '0; post_rst = 1;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete(); ref_q[i].delete(); pause[i] = 0;
    end
    drive_inputs();
  endtask

  task automatic step_model();
    bit xfer, in_pay;
    int c;
    hs = '0;
    if (post_rst) begin
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_outputs", 32'({busy, grant, tx_valid, req_ready, overrun}), 0);
      post_rst = 0;
    end
    if (prev_hold) begin
      check("hold_valid", 32'(tx_valid), 1);
      check("hold_data", 32'(tx_data), 32'(prev_data));
    end
    check("overrun", 32'(overrun), 32'(ovr_due));
    if (overrun) ovr_count++;
    ovr_due = 0;
    check("busy", 32'(busy), 32'(m_busy));
    if (busy && !prev_busy) begin
      grant_log.push_back(grant);
      start_log.push_back(cyc);
    end
    xfer = tx_valid && !tx_full;
    if (!m_busy) begin
      check("idle_grant", 32'(grant), 0);
      check("idle_tx_valid", 32'(tx_valid), 0);
      check("idle_ready", 32'(req_ready), 0);
      if (|req_valid) begin
        for (int k = N - 1; k >= 0; k--) begin
          c = (m_ptr + k) % N;
          if (req_valid[c]) m_idx = c;
        end
        m_ptr  = (m_idx + 1) % N;
        build_frame(m_idx);
        m_pos  = 0;
        m_busy = 1;
      end
    end else begin
      in_pay = (m_pos >= 2) && (m_pos < m_frame.size() - 1);
      check("grant", 32'(grant), 32'd1 << m_idx);
      check("tx_valid", 32'(tx_valid), in_pay ? 32'(req_valid[m_idx]) : 1);
      check("req_ready", 32'(req_ready), (in_pay && !tx_full) ? (32'd1 << m_idx) : 0);
      if (in_pay && tx_valid && tx_full) stall_cycles++;
      if (xfer) begin
        check("tx_data", 32'(tx_data), 32'(m_frame[m_pos]));
        wire_log.push_back(tx_data);
        if (test_mode == 5 && m_pos == 3) rst_arm = 1;
        if (m_ovr_frame && m_pos == m_frame.size() - 2) ovr_due = 1;
        m_pos++;
        if (m_pos == m_frame.size()) m_busy = 0;
      end
      if (test_mode == 3 && !full_done && m_busy && m_pos == 3) begin
        full_hold = 5;
        full_done = 1;
      end
    end
    hs        = req_valid & req_ready;
    prev_hold = tx_valid && tx_full;
    prev_data = tx_data;
    prev_busy = busy;
  endtask

  initial begin : cycle_loop
    rst = 1'b1; init_left = 3; tx_full = 1'b0;
    for (int i = 0; i < N; i++) pause[i] = 0;
    drive_inputs();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) model_reset();
      else     step_model();
      @(posedge clk);
      #1;
      if (rst_arm) begin rst = 1'b1; rst_arm = 0; end
      else if (init_left > 0) init_left--;
      else rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (!tx_full) pause[i] = ($urandom_range(99) < pause_pct);
      end
      if (full_hold > 0) begin tx_full = 1'b1; full_hold--; end
      else tx_full = ($urandom_range(99) < full_pct);
      drive_inputs();
    end
  end

  task automatic wait_idle(input int budget);
    int t;
    bit pending;
    t = 0;
    pending = 1;
    while (t < budget && pending) begin
      @(posedge clk);
      t++;
      pending = m_busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1;
    end
    check("idle_timeout", 32'(t < budget), 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic check_wire(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(wire_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < wire_log.size(); i++) begin
      check(name, 32'(wire_log[i]), 32'(exp[i]));
    end
  endtask

  task automatic clear_logs();
    wire_log.delete(); grant_log.delete(); start_log.delete();
  endtask

  initial begin : main
    logic [7:0] exp_q [$];
    int nb;
    repeat (6) @(posedge clk);
    #2;

    // Single 2-byte packet from requester 0.
    test_mode = 1; clear_logs();
    push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1);
    wait_idle(200);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03};
    check_wire("t1_wire", exp_q);

    // Simultaneous requesters 1 and 2.
    test_mode = 2; clear_logs();
    push_byte(1, 8'h10, 1); push_byte(2, 8'h20, 1);
    wait_idle(200);
    exp_q = '{8'hA5, 8'h01, 8'h10, 8'h11, 8'hA5, 8'h02, 8'h20, 8'h22};
    check_wire("t2_wire", exp_q);
    check("t2_grant_cnt", 32'(grant_log.size()), 2);
    if (grant_log.size() == 2) begin
      check("t2_grant0", 32'(grant_log[0]), 32'h2);
      check("t2_grant1", 32'(grant_log[1]), 32'h4);
    end

    // Five-cycle full stall in the middle of the payload.
    test_mode = 3; clear_logs(); stall_cycles = 0;
    push_byte(2, 8'h11, 0); push_byte(2, 8'h22, 0); push_byte(2, 8'h33, 1);
    wait_idle(200);
    exp_q = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h68};
    check_wire("t3_wire", exp_q);
    check("t3_stall_cycles", 32'(stall_cycles), 5);

    // 40-byte stream from requester 3 is cut at 32 bytes.
    test_mode = 4; clear_logs(); ovr_count = 0;
    for (int i = 0; i < 40; i++) push_byte(3, 8'h01, i == 39);
    wait_idle(500);
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
    for (int i = 0; i < 32; i++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h23);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h03);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h01);
    exp_q.push_back(8'h0B);
    check_wire("t4_wire", exp_q);
    check("t4_overruns", 32'(ovr_count), 1);

    // Reset after the second payload byte, then arbitration from requester 0.
    test_mode = 5; clear_logs();
    push_byte(1, 8'hB0, 0); push_byte(1, 8'hB1, 0); push_byte(1, 8'hB2, 0); push_byte(1, 8'hB3, 1);
    wait_idle(200);
    test_mode = 0;
    exp_q = '{8'hA5, 8'h01, 8'hB0, 8'hB1};
    check_wire("t5_wire", exp_q);
    clear_logs();
    push_byte(0, 8'h40, 1); push_byte(3, 8'h43, 1);
    wait_idle(200);
    exp_q = '{8'hA5, 8'h00, 8'h40, 8'h40, 8'hA5, 8'h03, 8'h43, 8'h46};
    check_wire("t5_after_wire", exp_q);
    check("t5_grant_cnt", 32'(grant_log.size()), 2);
    if (grant_log.size() == 2) begin
      check("t5_grant0", 32'(grant_log[0]), 32'h1);
      check("t5_grant1", 32'(grant_log[1]), 32'h8);
    end

    // All four requesters active, one-byte packets.
    test_mode = 6; clear_logs();
    for (int i = 0; i < N; i++) push_byte(i, 8'(8'h50 + i), 1);
    push_byte(0, 8'h54, 1);
    wait_idle(300);
    check("t6_grant_cnt", 32'(grant_log.size()), 5);
    if (grant_log.size() == 5) begin
      check("t6_g0", 32'(grant_log[0]), 32'h1);
      check("t6_g1", 32'(grant_log[1]), 32'h2);
      check("t6_g2", 32'(grant_log[2]), 32'h4);
      check("t6_g3", 32'(grant_log[3]), 32'h8);
      check("t6_g4", 32'(grant_log[4]), 32'h1);
      for (int i = 1; i < 5; i++) check("t6_frame_spacing", 32'(start_log[i] - start_log[i-1]), 5);
    end

    // Randomised traffic with back-pressure and requester stalls.
    test_mode = 7; clear_logs(); full_pct = 30; pause_pct = 20;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++) begin
        nb = int'($urandom_range(40, 1));
        for (int b = 0; b < nb; b++) push_byte(i, 8'($urandom_range(255)), b == nb - 1);
      end
    end
    wait_idle(20000);
    full_pct = 0; pause_pct = 0;
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
